// File: rtl/module_captura_entrada_if.sv
// rtl/module_captura_entrada_if.sv - switch/button inputs and captured Hamming operands
interface module_captura_entrada_if;
   logic [3:0] sw_dato_i;
   logic [6:0] sw_palabra_i;
   logic       btn_cargar_i;
   logic [3:0] entrada_o;
   logic [6:0] palabra_o;
   logic       valido_o;
   logic       cargado_o;

   modport master (
      output sw_dato_i, sw_palabra_i, btn_cargar_i,
      input  entrada_o, palabra_o, valido_o, cargado_o
   );

   modport slave (
      input  sw_dato_i, sw_palabra_i, btn_cargar_i,
      output entrada_o, palabra_o, valido_o, cargado_o
   );
endinterface

// File: rtl/module_captura_entrada.sv
// rtl/module_captura_entrada.sv - sync/debounce raw switches and button, capture one operand pair per press
module module_captura_entrada #(
   parameter int DEBOUNCE_CYCLES = 270000
) (
   input  logic                       clk,
   input  logic                       rst,
   module_captura_entrada_if.slave    bus
);
   localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
   localparam int NB = 12;

   typedef enum logic {IDLE, ESPERA} state_t;

   // Bit map: [3:0] data, [10:4] codeword, [11] button
   logic [NB-1:0] raw;
   logic [NB-1:0] sync1_q, sync2_q, acc_q;
   logic [CW-1:0] cnt_q [NB];

   state_t     state_q, state_d;
   logic [3:0] entrada_q, entrada_d;
   logic [6:0] palabra_q, palabra_d;
   logic       valido_q, valido_d;
   logic       cargado_q, cargado_d;
   logic       btn_db;

   assign raw    = {bus.btn_cargar_i, bus.sw_palabra_i, bus.sw_dato_i};
   assign btn_db = acc_q[11];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1_q <= '0;
         sync2_q <= '0;
         acc_q   <= '0;
         for (int i = 0; i < NB; i++) cnt_q[i] <= '0;
      end else begin
         sync1_q <= raw;
         sync2_q <= sync1_q;
         // Any matching sample restarts the count, so bounces never accumulate
         for (int i = 0; i < NB; i++) begin
            if (sync2_q[i] == acc_q[i]) begin
               cnt_q[i] <= '0;
            end else if (cnt_q[i] == CNT_LAST) begin
               acc_q[i] <= sync2_q[i];
               cnt_q[i] <= '0;
            end else begin
               cnt_q[i] <= cnt_q[i] + CW'(1);
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         entrada_q <= 4'h0;
         palabra_q <= 7'h00;
         valido_q  <= 1'b0;
         cargado_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         entrada_q <= entrada_d;
         palabra_q <= palabra_d;
         valido_q  <= valido_d;
         cargado_q <= cargado_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      entrada_d = entrada_q;
      palabra_d = palabra_q;
      valido_d  = 1'b0;
      cargado_d = cargado_q;
      case (state_q)
         IDLE: begin
            if (btn_db) begin
               entrada_d = acc_q[3:0];
               palabra_d = acc_q[10:4];
               valido_d  = 1'b1;
               cargado_d = 1'b1;
               state_d   = ESPERA;
            end
         end
         ESPERA: begin
            // Wait for a debounced release so a held button captures once
            if (!btn_db) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign bus.entrada_o = entrada_q;
   assign bus.palabra_o = palabra_q;
   assign bus.valido_o  = valido_q;
   assign bus.cargado_o = cargado_q;
endmodule

// File: tb/tb_module_captura_entrada.sv
// tb/tb_module_captura_entrada.sv - directed bench for module_captura_entrada
module tb_module_captura_entrada;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   pass_cnt = 0;
   int   chk_cnt  = 0;

   module_captura_entrada_if bus ();

   module_captura_entrada #(.DEBOUNCE_CYCLES(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   always #5 clk = ~clk;

   task automatic sync_drive();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic watch(input int n, output int npulse, output int pos);
      npulse = 0;
      pos = 0;
      for (int i = 1; i <= n; i++) begin
         @(posedge clk);
         @(negedge clk);
         if (bus.valido_o === 1'b1) begin
            npulse++;
            if (pos == 0) pos = i;
         end
      end
   endtask

   task automatic check_outs(input string nm, input logic [3:0] e, input logic [6:0] p,
                             input logic v, input logic c);
      chk_cnt++;
      if (bus.entrada_o !== e) $display("FAIL %s entrada: got %h want %h", nm, bus.entrada_o, e);
      else pass_cnt++;
      chk_cnt++;
      if (bus.palabra_o !== p) $display("FAIL %s palabra: got %h want %h", nm, bus.palabra_o, p);
      else pass_cnt++;
      chk_cnt++;
      if (bus.valido_o !== v) $display("FAIL %s valido: got %b want %b", nm, bus.valido_o, v);
      else pass_cnt++;
      chk_cnt++;
      if (bus.cargado_o !== c) $display("FAIL %s cargado: got %b want %b", nm, bus.cargado_o, c);
      else pass_cnt++;
   endtask

   task automatic check_pulse(input string nm, input int npulse, input int pos, input int want_pos);
      chk_cnt++;
      if (npulse != 1) $display("FAIL %s pulse count: got %0d want 1", nm, npulse);
      else pass_cnt++;
      chk_cnt++;
      if (pos != want_pos) $display("FAIL %s pulse cycle: got %0d want %0d", nm, pos, want_pos);
      else pass_cnt++;
   endtask

   task automatic test_reset();
      int np, ps;
      bus.sw_dato_i    = 4'h0;
      bus.sw_palabra_i = 7'h00;
      bus.btn_cargar_i = 1'b0;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check_outs("reset_during", 4'h0, 7'h00, 1'b0, 1'b0);
      sync_drive();
      rst = 1'b0;
      watch(50, np, ps);
      chk_cnt++;
      if (np != 0) $display("FAIL reset_no_pulse: got %0d pulses want 0", np);
      else pass_cnt++;
      check_outs("reset_after", 4'h0, 7'h00, 1'b0, 1'b0);
   endtask

   task automatic test_capture();
      int np, ps;
      sync_drive();
      bus.sw_dato_i    = 4'b1011;
      bus.sw_palabra_i = 7'b0110011;
      wait_cycles(20);
      bus.btn_cargar_i = 1'b1;
      watch(30, np, ps);
      check_pulse("capture", np, ps, 7);
      check_outs("capture", 4'hB, 7'h33, 1'b0, 1'b1);
   endtask

   task automatic test_sticky();
      int np, ps;
      sync_drive();
      bus.sw_dato_i = 4'h5;
      wait_cycles(25);
      chk_cnt++;
      if (bus.entrada_o !== 4'hB) $display("FAIL sticky_hold: got %h want b", bus.entrada_o);
      else pass_cnt++;
      bus.btn_cargar_i = 1'b0;
      wait_cycles(10);
      bus.btn_cargar_i = 1'b1;
      watch(30, np, ps);
      check_pulse("sticky_repress", np, ps, 7);
      check_outs("sticky_repress", 4'h5, 7'h33, 1'b0, 1'b1);
   endtask

   task automatic test_bounce();
      int pat [9] = '{1, 0, 1, 1, 1, 0, 1, 1, 0};
      int np, ps;
      sync_drive();
      bus.btn_cargar_i = 1'b0;
      bus.sw_dato_i    = 4'hA;
      bus.sw_palabra_i = 7'h55;
      wait_cycles(20);
      np = 0;
      ps = -1;
      for (int j = 0; j < 39; j++) begin
         bus.btn_cargar_i = (j < 9) ? pat[j][0] : 1'b1;
         @(posedge clk);
         @(negedge clk);
         if (bus.valido_o === 1'b1) begin
            np++;
            if (ps < 0) ps = j;
         end
      end
      check_pulse("bounce", np, ps, 15);
      check_outs("bounce", 4'hA, 7'h55, 1'b0, 1'b1);
   endtask

   task automatic test_late_switch();
      int np, ps;
      sync_drive();
      bus.btn_cargar_i = 1'b0;
      bus.sw_dato_i    = 4'h3;
      wait_cycles(20);
      bus.btn_cargar_i = 1'b1;
      np = 0;
      ps = 0;
      for (int i = 1; i <= 30; i++) begin
         @(posedge clk);
         @(negedge clk);
         if (bus.valido_o === 1'b1) begin
            np++;
            if (ps == 0) ps = i;
         end
         if (i == 3) bus.sw_dato_i = 4'hC;
      end
      check_pulse("late_switch", np, ps, 7);
      chk_cnt++;
      if (bus.entrada_o !== 4'h3) $display("FAIL late_switch_value: got %h want 3", bus.entrada_o);
      else pass_cnt++;
   endtask

   task automatic test_reset_mid();
      int np, ps;
      bit found;
      sync_drive();
      bus.btn_cargar_i = 1'b0;
      wait_cycles(12);
      bus.btn_cargar_i = 1'b1;
      found = 1'b0;
      for (int i = 1; i <= 20 && !found; i++) begin
         @(posedge clk);
         @(negedge clk);
         if (bus.valido_o === 1'b1) found = 1'b1;
      end
      chk_cnt++;
      if (!found) $display("FAIL reset_mid_pulse_seen: got 0 want 1");
      else pass_cnt++;
      rst = 1'b1;
      #1;
      check_outs("reset_mid", 4'h0, 7'h00, 1'b0, 1'b0);
      sync_drive();
      rst = 1'b0;
      watch(30, np, ps);
      check_pulse("reset_mid_recapture", np, ps, 7);
      check_outs("reset_mid_recapture", 4'hC, 7'h55, 1'b0, 1'b1);
   endtask

   initial begin
      test_reset();
      test_capture();
      test_sticky();
      test_bounce();
      test_late_switch();
      test_reset_mid();
      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end
endmodule
